hc154_line_driver: RTL and testbench
====================================

# hc154_line_driver

Sequenced 4-to-16 line driver: the decode-side counterpart to the cascaded 16-line priority encoder and display path. Accepts a 4-bit line code over a valid/ready handshake and drives the matching active-low line (74HC154 convention) for a programmable number of cycles. Each pulse is followed by a break-before-make gap. Sits between a code source (encoder output, CPU register, or test sequencer) and the lamp/relay/segment-select lines.

## Interface
Parameters:
- HOLD, default 4: cycles a selected line is held low; legal range 1..255.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EI  in  1  active-low enable (HC148/HC154 convention); high blocks acceptance and aborts a pulse in progress.
- Code  in  4  line index 0..15.
- Valid  in  1  Code is valid this cycle.
- Ready  out  1  block accepts Code this cycle; transfer occurs when Valid and Ready are both high at a rising edge.
- Line_N  out  16  active-low decoded lines; at most one bit low at any time.
- GS  out  1  active-low group select; low exactly when some Line_N bit is low.
- Busy  out  1  high in DRIVE or GAP.
- Scan  in  1  auto-scan request; present only with HC154_SCAN_EN.

## Operation
- States: IDLE, DRIVE, GAP.
- IDLE:
  - Line_N = 16'hFFFF, GS = 1, Busy = 0, Ready = ~EI (combinational).
  - On transfer: latch Code, load hold counter with HOLD-1, go to DRIVE.
- DRIVE:
  - Line_N[code_q] = 0, GS = 0, Busy = 1, Ready = 0.
  - The counter decrements each cycle. At 0, go to GAP.
  - If EI is high at any edge in DRIVE, go to GAP immediately (abort).
- GAP: exactly one cycle with all lines high, GS = 1, Busy = 1, Ready = 0; then go to IDLE.
- Line_N, GS and Busy are registered outputs. Ready is the only combinational output.
- Code is ignored unless a transfer occurs. Valid without Ready is held off: the source must keep Valid and Code stable until the transfer.
- Hold counter width is 8 bits; no wrap, since HOLD ≤ 255.

## Timing
- Reset: Line_N = 16'hFFFF, GS = 1, Busy = 0, state = IDLE. Ready is therefore ~EI in the first cycle after reset.
- RST asserted mid-DRIVE: lines released at that edge. No GAP cycle is inserted, and the latched code is discarded.
- Latency: a transfer at edge N gives Line_N low from edge N+1 through edge N+HOLD. GAP runs N+HOLD to N+HOLD+1. Ready is high again from edge N+HOLD+1.
- Throughput: one code per HOLD+2 cycles, counting the IDLE cycle that carries the transfer.
- Abort: EI high at edge M during DRIVE releases lines at M. GAP occupies M to M+1, then IDLE; Ready stays low while EI is high.
- No two line bits are ever simultaneously low, including across back-to-back codes, because GAP is always inserted.

## Configuration
- HC154_SCAN_EN defined: adds the Scan port.
  - In IDLE with Scan = 1, EI = 0 and Valid = 0, the block self-issues the next scan index as if transferred. The index starts at 0 after reset and increments mod 16 (15 wraps to 0).
  - Ready stays ~EI; an external transfer has priority over a scan step in the same cycle and does not advance the scan index.
  - Dropping Scan mid-pulse finishes that pulse normally.
- Not defined: no Scan port and no scan index register; behaviour is exactly as described above.

## Structure
- Shared package hc_pkg:
  - LINES = 16, CODE_W = 4, HOLD_W = 8.
  - State enum typedef (IDLE, DRIVE, GAP).
  - One-hot-low decode function (code → 16-bit active-low mask), shared with future display/mux blocks.
- One sub-module, hc_hold_timer: loadable 8-bit down-counter with load, enable and zero flag. Reused by later strobe/blink blocks.

## Test plan
- HOLD=3, EI=0, Code=5 with Valid for 1 cycle at edge 10:
  - Line_N = 16'hFFDF and GS = 0 for edges 11–13.
  - All lines high at edge 14; Ready = 1 at edge 15.
- Back-to-back codes 0 then 15 with Valid held high: never more than one low bit; exactly one all-high GAP cycle between the 16'hFFFE and 16'h7FFF pulses.
- EI raised one cycle into a HOLD=4 pulse on Code=9: line released at that edge, one GAP cycle, Ready stays 0 until EI = 0.
- RST pulsed mid-DRIVE:
  - Next edge gives Line_N = 16'hFFFF, GS = 1, Busy = 0.
  - Valid asserted with Code=2 immediately after reset is accepted once EI = 0.
- HC154_SCAN_EN, HOLD=1, Scan=1, Valid=0: lines 0,1,…,15,0 asserted in order, each pulse 3 cycles apart.
- HC154_SCAN_EN, external Valid with Code=7 mid-scan: line 7 driven, then scan resumes at the index it would have issued next.

Source files
------------

// File: rtl/hc154_line_driver_pkg.sv
// Shared definitions for the HC154-style line driver and future display/mux blocks:
// geometry constants, FSM state type and the one-hot-low line decode.
package hc_pkg;

    localparam int LINES  = 16;
    localparam int CODE_W = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } hc_state_e;

    // Active-low one-hot mask: only the bit selected by code is driven low.
    function automatic logic [LINES-1:0] hc_decode_n(input logic [CODE_W-1:0] code);
        logic [LINES-1:0] mask;
        mask       = {LINES{1'b1}};
        mask[code] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/hc154_line_driver_if.sv
// Code-source / line-output bundle for hc154_line_driver.
// The Scan request only exists when HC154_SCAN_EN is defined.
interface hc154_line_driver_if;
    import hc_pkg::*;

    logic                EI;
    logic [CODE_W-1:0]   Code;
    logic                Valid;
    logic                Ready;
    logic [LINES-1:0]    Line_N;
    logic                GS;
    logic                Busy;
`ifdef HC154_SCAN_EN
    logic                Scan;

    modport slave  (input  EI, Code, Valid, Scan,
                    output Ready, Line_N, GS, Busy);
    modport master (output EI, Code, Valid, Scan,
                    input  Ready, Line_N, GS, Busy);
`else
    modport slave  (input  EI, Code, Valid,
                    output Ready, Line_N, GS, Busy);
    modport master (output EI, Code, Valid,
                    input  Ready, Line_N, GS, Busy);
`endif

endinterface

// File: rtl/hc154_line_driver_timer.sv
// hc_hold_timer: loadable down-counter with enable and zero flag.
// Saturates at zero so an idle enable never wraps.
module hc_hold_timer
    import hc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [HOLD_W-1:0] load_val_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Next count: load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {HOLD_W{1'b0}})) begin
            cnt_d = cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {HOLD_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {HOLD_W{1'b0}});

endmodule

// File: rtl/hc154_line_driver.sv
// Sequenced 4-to-16 active-low line driver: IDLE -> DRIVE (HOLD cycles) -> GAP (1 cycle).
// Optional auto-scan selected with the HC154_SCAN_EN macro.
module hc154_line_driver
    import hc_pkg::*;
#(
    parameter int HOLD = 4
)(
    input  logic                CLK,
    input  logic                RST,
    hc154_line_driver_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

    hc_state_e          state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [LINES-1:0]   line_n_q, line_n_d;
    logic               gs_q, gs_d;
    logic               busy_q, busy_d;

    logic               ready_s;
    logic               start_s;
    logic [CODE_W-1:0]  start_code_s;
    logic               tmr_load_s;
    logic               tmr_en_s;
    logic               tmr_zero_s;

`ifdef HC154_SCAN_EN
    logic [CODE_W-1:0]  scan_q, scan_d;
`endif

    assign ready_s = (state_q == IDLE) && !bus.EI;

    // Start request: an external transfer, or (scan build) a self-issued scan step.
    always_comb begin
        start_s      = 1'b0;
        start_code_s = bus.Code;
`ifdef HC154_SCAN_EN
        scan_d       = scan_q;
`endif
        if (ready_s && bus.Valid) begin
            start_s      = 1'b1;
            start_code_s = bus.Code;
`ifdef HC154_SCAN_EN
        end else if (ready_s && bus.Scan) begin
            start_s      = 1'b1;
            start_code_s = scan_q;
            scan_d       = scan_q + {{(CODE_W-1){1'b0}}, 1'b1};
`endif
        end else begin
            start_s      = 1'b0;
        end
    end

    // Next state and next registered outputs; outputs default to all lines released.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        line_n_d   = {LINES{1'b1}};
        gs_d       = 1'b1;
        busy_d     = 1'b0;
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d    = DRIVE;
                    code_d     = start_code_s;
                    tmr_load_s = 1'b1;
                    line_n_d   = hc_decode_n(start_code_s);
                    gs_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            DRIVE: begin
                // An abort and a natural timeout both release the lines into GAP.
                if (bus.EI || tmr_zero_s) begin
                    state_d  = GAP;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = DRIVE;
                    tmr_en_s = 1'b1;
                    line_n_d = hc_decode_n(code_q);
                    gs_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset releases every line without a GAP cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            code_q   <= {CODE_W{1'b0}};
            line_n_q <= {LINES{1'b1}};
            gs_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            line_n_q <= line_n_d;
            gs_q     <= gs_d;
            busy_q   <= busy_d;
        end
    end

`ifdef HC154_SCAN_EN
    // Scan index register; restarts at line 0 after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_q <= {CODE_W{1'b0}};
        end else begin
            scan_q <= scan_d;
        end
    end
`endif

    hc_hold_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load_s),
        .en_i       (tmr_en_s),
        .load_val_i (HOLD_LOAD),
        .zero_o     (tmr_zero_s)
    );

    assign bus.Ready  = ready_s;
    assign bus.Line_N = line_n_q;
    assign bus.GS     = gs_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_hc154_line_driver.sv
// Randomized bench for hc154_line_driver against a timeline model: each transfer
// schedules its release and idle edges, an abort or reset reschedules them.
module tb_hc154_line_driver;

    localparam int HOLD = 3;

    logic CLK;
    logic RST;

    hc154_line_driver_if bus ();

    hc154_line_driver #(.HOLD(HOLD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edge counter, last edge with a line low, first edge after which block is idle.
    int         cyc       = 0;
    int         low_until = -1;
    int         idle_at   = 0;
    logic [3:0] line_m    = 4'd0;
    logic [3:0] scan_m    = 4'd0;
    bit         model_ok  = 1'b0;
    bit         ext_xfer  = 1'b0;

    bit         src_pend  = 1'b0;
    logic [3:0] src_code  = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick(input logic rst, input logic ei, input logic valid,
                        input logic [3:0] code, input logic scan);
        bit         idle_b;
        bit         xfer;
        int         t;
        logic [15:0] exp_line;
        RST       = rst;
        bus.EI    = ei;
        bus.Valid = valid;
        bus.Code  = code;
`ifdef HC154_SCAN_EN
        bus.Scan  = scan;
`endif
        #1;
        idle_b = (idle_at < cyc + 1);
        if (model_ok) chk("ready", {31'd0, bus.Ready}, {31'd0, idle_b && !ei});
        @(posedge CLK);
        cyc++;
        t        = cyc;
        xfer     = 1'b0;
        ext_xfer = 1'b0;
        if (rst) begin
            low_until = t - 1;
            idle_at   = t;
            scan_m    = 4'd0;
            model_ok  = 1'b1;
        end else if (idle_b) begin
            if (valid && !ei) begin
                line_m   = code;
                xfer     = 1'b1;
                ext_xfer = 1'b1;
`ifdef HC154_SCAN_EN
            end else if (scan && !ei) begin
                line_m = scan_m;
                scan_m = scan_m + 4'd1;
                xfer   = 1'b1;
`endif
            end
            if (xfer) begin
                low_until = t + HOLD - 1;
                idle_at   = t + HOLD + 1;
            end
        end else if ((t - 1 <= low_until) && ei) begin
            low_until = t - 1;
            idle_at   = t + 1;
        end
        @(negedge CLK);
        if (model_ok) begin
            exp_line = (t <= low_until) ? ~(16'h0001 << line_m) : 16'hFFFF;
            chk("line_n", {16'd0, bus.Line_N}, {16'd0, exp_line});
            chk("gs",     {31'd0, bus.GS},     {31'd0, !(t <= low_until)});
            chk("busy",   {31'd0, bus.Busy},   {31'd0, t < idle_at});
            chk("onehot", {31'd0, $countones(~bus.Line_N) <= 1}, 32'd1);
        end
    endtask

    // Hold Valid/Code until accepted, bounded so a stuck Ready cannot hang the run.
    task automatic send(input logic [3:0] code);
        int tries;
        tries = 0;
        ext_xfer = 1'b0;
        while (!ext_xfer && tries < 20) begin
            tick(1'b0, 1'b0, 1'b1, code, 1'b0);
            tries++;
        end
        chk("accept", {31'd0, ext_xfer}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        RST       = 1'b1;
        bus.EI    = 1'b0;
        bus.Valid = 1'b0;
        bus.Code  = 4'd0;
`ifdef HC154_SCAN_EN
        bus.Scan  = 1'b0;
`endif
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_line", {16'd0, bus.Line_N}, 32'h0000_FFFF);
        idle(3);

        // Single pulse on line 5.
        tick(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        chk("pulse5", {16'd0, bus.Line_N}, 32'h0000_FFDF);
        idle(6);

        // Back-to-back 0 then 15 with Valid held high.
        send(4'd0);
        send(4'd15);
        idle(6);

        // Abort one cycle into a pulse on line 9; EI held high for a while.
        send(4'd9);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        idle(3);

        // Reset mid-drive, then code 2 offered with EI high before being accepted.
        send(4'd4);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
        send(4'd2);
        idle(6);

`ifdef HC154_SCAN_EN
        // Auto-scan with an external code injected mid-scan.
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        send(4'd7);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
`endif

        // Random traffic honouring the hold-off rule for Valid/Code.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_ei, r_scan;
            if (!src_pend && ($urandom_range(0, 2) == 0)) begin
                src_pend = 1'b1;
                src_code = 4'($urandom_range(0, 15));
            end
            r_rst  = ($urandom_range(0, 99) == 0);
            r_ei   = ($urandom_range(0, 9) == 0);
            r_scan = ($urandom_range(0, 3) != 0);
            tick(r_rst, r_ei, src_pend, src_code, r_scan);
            if (ext_xfer) src_pend = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
